pipelined_addsub: RTL

- Parametrised, pipelined add/subtract unit. Successor to the fixed 4-bit registered adder.
- Splits a WIDTH-bit carry chain into STAGES registered segments, so wide adds close timing at high clock rates.
- Adds valid/ready flow control with backpressure, a subtract mode, carry-in, and a signed-overflow flag.
- Sits between register-to-register datapath blocks that need one result per cycle.

---
 rtl/pipelined_addsub.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit.
// A WIDTH-bit carry chain is cut into STAGES registered segments of SEG bits.
// Each stage resolves one segment from the carry registered by the previous
// stage. Operand bits not yet consumed ride along beside the partial sum.
// A single global advance signal moves the whole pipe, or holds it on backpressure.

// One pipeline segment.
// Input word layout:  {b_rem, a_rem, sum_done}
//   sum_done : DONE_IN bits that are already resolved
//   a_rem    : upper operand A bits that are not yet consumed
//   b_rem    : upper effective operand B bits that are not yet consumed
// Output word layout: same layout with SEG more bits resolved.
// The final stage instead emits {ovf, sum}.
module pipelined_addsub_stage #(
    parameter int WIDTH   = 16,
    parameter int SEG     = 4,
    parameter int DONE_IN = 0,
    parameter bit LAST    = 1'b0,
    localparam int REM_IN  = WIDTH - DONE_IN,
    localparam int IN_W    = WIDTH + REM_IN,
    localparam int REM_OUT = REM_IN - SEG,
    localparam int OUT_W   = LAST ? (WIDTH + 1) : (WIDTH + REM_OUT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance_i,
    input  logic             valid_i,
    input  logic             carry_i,
    input  logic [IN_W-1:0]  data_i,
    output logic             valid_o,
    output logic             carry_o,
    output logic [OUT_W-1:0] data_o
);

    logic [SEG:0]       seg_res_s;
    logic [WIDTH-1:0]   low_s;
    logic               carry_d;
    logic [OUT_W-1:0]   data_d;
    logic               valid_q;
    logic               carry_q;
    logic [OUT_W-1:0]   data_q;

    // Resolve this segment and splice it into place over the consumed A bits
    always_comb begin
        seg_res_s = {1'b0, data_i[DONE_IN +: SEG]}
                  + {1'b0, data_i[WIDTH +: SEG]}
                  + {{SEG{1'b0}}, carry_i};
        low_s = data_i[WIDTH-1:0];
        low_s[DONE_IN +: SEG] = seg_res_s[SEG-1:0];
        carry_d = seg_res_s[SEG];
    end

    if (LAST) begin : g_last
        // All operand MSBs are still present here, so overflow is resolved in this stage
        logic a_msb_s;
        logic b_msb_s;
        logic ovf_s;
        assign a_msb_s = data_i[WIDTH-1];
        assign b_msb_s = data_i[IN_W-1];
        assign ovf_s   = (a_msb_s == b_msb_s) && (low_s[WIDTH-1] != a_msb_s);
        assign data_d  = {ovf_s, low_s};
    end else begin : g_mid
        // Drop the B segment that was just consumed and keep the rest of B
        assign data_d = {data_i[IN_W-1 -: REM_OUT], low_s};
    end

    // Stage register: load on advance, hold everything while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            data_q  <= {OUT_W{1'b0}};
        end else if (advance_i) begin
            valid_q <= valid_i;
            carry_q <= carry_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign carry_o = carry_q;
    assign data_o  = data_q;

endmodule

module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    // Bit offset of stage k's output word inside the flat inter-stage bus.
    // Stage j emits 2*WIDTH-(j+1)*SEG bits; the final stage emits WIDTH+1.
    function automatic int stage_off(input int k);
        stage_off = k * 2 * WIDTH - (SEG * k * (k + 1)) / 2;
    endfunction

    localparam int BUS_W = stage_off(STAGES - 1) + WIDTH + 1;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_addsub: STAGES must lie in 1..WIDTH and divide WIDTH");
    end

    logic [WIDTH-1:0]  b_eff_s;
    logic              c0_s;
    logic              advance_s;
    logic [STAGES-1:0] valid_s;
    logic [STAGES-1:0] carry_s;
    logic [BUS_W-1:0]  bus_s;

    // Condition operands: subtraction is A + ~B + 1, and it ignores cin
    always_comb begin
        b_eff_s = b;
        c0_s    = cin;
        if (sub) begin
            b_eff_s = ~b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = b;
            c0_s    = cin;
        end
    end

    // The whole pipe moves together.
    // A held output beat freezes every stage, and bubbles are not collapsed.
    assign advance_s = !valid_s[STAGES-1] || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = 2 * WIDTH - k * SEG;
        localparam int OUT_W = (k == STAGES - 1) ? (WIDTH + 1) : (2 * WIDTH - (k + 1) * SEG);

        logic [IN_W-1:0] data_in_s;
        logic            valid_in_s;
        logic            carry_in_s;

        if (k == 0) begin : g_first
            assign data_in_s  = {b_eff_s, a};
            assign valid_in_s = in_valid;
            assign carry_in_s = c0_s;
        end else begin : g_next
            assign data_in_s  = bus_s[stage_off(k - 1) +: IN_W];
            assign valid_in_s = valid_s[k - 1];
            assign carry_in_s = carry_s[k - 1];
        end

        pipelined_addsub_stage #(
            .WIDTH   (WIDTH),
            .SEG     (SEG),
            .DONE_IN (k * SEG),
            .LAST    (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance_i (advance_s),
            .valid_i   (valid_in_s),
            .carry_i   (carry_in_s),
            .data_i    (data_in_s),
            .valid_o   (valid_s[k]),
            .carry_o   (carry_s[k]),
            .data_o    (bus_s[stage_off(k) +: OUT_W])
        );
    end

    // The final stage registers are the output registers
    assign out_valid = valid_s[STAGES-1];
    assign cout      = carry_s[STAGES-1];
    assign sum       = bus_s[stage_off(STAGES - 1) +: WIDTH];
    assign ovf       = bus_s[stage_off(STAGES - 1) + WIDTH];

endmodule
